// File: rtl/stack_row_controller.sv
// ----------------------------------------------------------------------------
// stack_row_controller
//   Sequences one stacking round of the block-stacker game. The active row
//   sweeps left/right at the frame-based speed set by the level FSM. A place
//   press locks the row and trims it to its overlap with the row below. A
//   successful placement pulses next_signal. A miss ends in OVER, and a
//   successful placement at MAX_LEVEL ends in WIN.
//
//   Optional feature macro: SCORE_EN (adds a saturating 16-bit score output).
//
// Ports
//   clk          system clock
//   resetn       synchronous reset, active HIGH despite the name
//   go           start/restart request (level)
//   place        one-cycle place pulse
//   frame_tick   one-cycle frame strobe
//   speed_count  frames per column step (0 acts as 1)
//   num_blocks   max row width for this level (0 acts as 1)
//   curr_level   current level
//   row_mask     moving row, bit i = column i
//   base_mask    locked row below the moving row
//   next_signal  one-cycle pulse on successful placement
//   game_over    high while in OVER
//   win          high while in WIN
//   draw_req     one-cycle pulse when row_mask or base_mask changes
//   score        (SCORE_EN only) accumulated score
// ----------------------------------------------------------------------------
module stack_row_controller #(
    parameter int unsigned COLS      = 16,
    parameter int unsigned MAX_LEVEL = 15
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            go,
    input  logic            place,
    input  logic            frame_tick,
    input  logic [5:0]      speed_count,
    input  logic [3:0]      num_blocks,
    input  logic [3:0]      curr_level,
    output logic [COLS-1:0] row_mask,
    output logic [COLS-1:0] base_mask,
    output logic            next_signal,
    output logic            game_over,
    output logic            win,
    output logic            draw_req
`ifdef SCORE_EN
    ,
    output logic [15:0]     score
`endif
);

    localparam int unsigned PW = $clog2(COLS);
    localparam int unsigned WW = PW + 1;
    localparam int unsigned MW = COLS + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_MOVE, S_LOCK, S_ADVANCE, S_OVER, S_WIN
    } state_e;

    state_e          state_q;
    logic [COLS-1:0] row_mask_q, base_mask_q;
    logic [PW-1:0]   pos_q;
    logic [WW-1:0]   width_q;
    logic            dir_right_q;
    logic [5:0]      tick_cnt_q;
    logic            next_q, over_q, win_q, draw_q;

    function automatic logic [WW-1:0] popcount(input logic [COLS-1:0] m);
        logic [WW-1:0] c;
        c = '0;
        for (int i = 0; i < COLS; i++) c = c + WW'(m[i]);
        return c;
    endfunction

    // Contiguous run of w ones starting at column p.
    function automatic logic [COLS-1:0] make_mask(input logic [WW-1:0] w, input logic [PW-1:0] p);
        logic [MW-1:0] ones;
        ones = (MW'(1) << w) - MW'(1);
        return COLS'(ones) << p;
    endfunction

    // Spawn width, step timing and next position/direction
    logic [WW-1:0]   nb_eff, base_pop, spawn_w, pos_max;
    logic [5:0]      spd_eff;
    logic            step_due, step_right;
    logic [PW-1:0]   step_pos;
    logic [COLS-1:0] overlap;

    always_comb begin
        nb_eff     = (num_blocks == 4'd0) ? WW'(1) : WW'(num_blocks);
        base_pop   = popcount(base_mask_q);
        spawn_w    = (nb_eff < base_pop) ? nb_eff : base_pop;
        if (spawn_w == '0) spawn_w = WW'(1);
        spd_eff    = (speed_count == 6'd0) ? 6'd1 : speed_count;
        step_due   = (tick_cnt_q + 6'd1) >= spd_eff;
        pos_max    = WW'(COLS) - width_q;
        // Bounce at either wall: flip direction and step the other way at once.
        step_right = dir_right_q;
        if (dir_right_q && (WW'(pos_q) >= pos_max)) step_right = 1'b0;
        else if (!dir_right_q && (pos_q == '0))    step_right = 1'b1;
        step_pos   = step_right ? (pos_q + PW'(1)) : (pos_q - PW'(1));
        overlap    = row_mask_q & base_mask_q;
    end

`ifdef SCORE_EN
    logic [15:0] score_q, score_sum;
    logic [16:0] score_wide;

    // Saturating score update for the ADVANCE cycle.
    always_comb begin
        score_wide = 17'(score_q) + (17'(base_pop) * 17'(curr_level));
        score_sum  = score_wide[16] ? 16'hFFFF : score_wide[15:0];
    end
    assign score = score_q;
`endif

    // Round sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= S_IDLE;
            row_mask_q  <= '0;
            base_mask_q <= '1;
            pos_q       <= '0;
            width_q     <= WW'(1);
            dir_right_q <= 1'b1;
            tick_cnt_q  <= '0;
            next_q      <= 1'b0;
            over_q      <= 1'b0;
            win_q       <= 1'b0;
            draw_q      <= 1'b0;
`ifdef SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            next_q <= 1'b0;
            draw_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) state_q <= S_SPAWN;
                end
                S_SPAWN: begin
                    width_q     <= spawn_w;
                    pos_q       <= '0;
                    dir_right_q <= 1'b1;
                    tick_cnt_q  <= '0;
                    row_mask_q  <= make_mask(spawn_w, '0);
                    draw_q      <= 1'b1;
                    state_q     <= S_MOVE;
                end
                S_MOVE: begin
                    // Place wins over a same-cycle step, so lock sees the pre-step mask.
                    if (place) begin
                        state_q <= S_LOCK;
                    end else if (frame_tick) begin
                        if (step_due) begin
                            tick_cnt_q <= '0;
                            if (width_q != WW'(COLS)) begin
                                pos_q       <= step_pos;
                                dir_right_q <= step_right;
                                row_mask_q  <= make_mask(width_q, step_pos);
                                draw_q      <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 6'd1;
                        end
                    end
                end
                S_LOCK: begin
                    if (overlap == '0) begin
                        state_q <= S_OVER;
                    end else begin
                        base_mask_q <= overlap;
                        draw_q      <= 1'b1;
                        state_q     <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    next_q  <= 1'b1;
`ifdef SCORE_EN
                    score_q <= score_sum;
`endif
                    state_q <= (32'(curr_level) >= MAX_LEVEL) ? S_WIN : S_SPAWN;
                end
                S_OVER, S_WIN: begin
                    if (go) begin
                        draw_q      <= (base_mask_q != '1);
                        base_mask_q <= '1;
                        over_q      <= 1'b0;
                        win_q       <= 1'b0;
`ifdef SCORE_EN
                        score_q     <= '0;
`endif
                        state_q     <= S_SPAWN;
                    end else if (state_q == S_OVER) begin
                        over_q <= 1'b1;
                    end else begin
                        win_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign row_mask    = row_mask_q;
    assign base_mask   = base_mask_q;
    assign next_signal = next_q;
    assign game_over   = over_q;
    assign win         = win_q;
    assign draw_req    = draw_q;

endmodule

// File: tb/tb_stack_row_controller.sv
// ----------------------------------------------------------------------------
// tb_stack_row_controller
//   Table-driven opening sequence, hand-written corner cases, then random
//   stimulus compared cycle by cycle against an integer reference model.
// ----------------------------------------------------------------------------
module tb_stack_row_controller;

    localparam int COLS = 16;

    logic        clk = 1'b0;
    logic        resetn, go, place, frame_tick;
    logic [5:0]  speed_count;
    logic [3:0]  num_blocks, curr_level;
    logic [15:0] row_mask, base_mask;
    logic        next_signal, game_over, win, draw_req;
`ifdef SCORE_EN
    logic [15:0] score;
`endif

    stack_row_controller #(.COLS(16), .MAX_LEVEL(15)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go),
        .place       (place),
        .frame_tick  (frame_tick),
        .speed_count (speed_count),
        .num_blocks  (num_blocks),
        .curr_level  (curr_level),
        .row_mask    (row_mask),
        .base_mask   (base_mask),
        .next_signal (next_signal),
        .game_over   (game_over),
        .win         (win),
        .draw_req    (draw_req)
`ifdef SCORE_EN
        ,
        .score       (score)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b1; go = 1'b0; place = 1'b0; frame_tick = 1'b0;
        step();
        resetn = 1'b0;
    endtask

    task automatic start_round();
        go = 1'b1; step();
        go = 1'b0; step();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic place_now();
        place = 1'b1; step();
        place = 1'b0;
    endtask

    // ---------------- reference model (plain integers) ----------------
    localparam int PH_IDLE = 0, PH_SPAWN = 1, PH_MOVE = 2, PH_LOCK = 3,
                   PH_ADV = 4, PH_OVER = 5, PH_WIN = 6;
    int          m_ph, m_pos, m_dir, m_w, m_cnt;
    logic [15:0] m_row, m_base;
    logic        m_next, m_over, m_win, m_draw;

    function automatic int pop16(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [15:0] mk(input int w, input int p);
        logic [31:0] t;
        t = ((32'd1 << w) - 32'd1) << p;
        return t[15:0];
    endfunction

    task automatic model_step();
        int np, sp, nb, ovl;
        if (resetn) begin
            m_ph = PH_IDLE; m_pos = 0; m_dir = 1; m_w = 1; m_cnt = 0;
            m_row = 16'h0; m_base = 16'hFFFF;
            m_next = 0; m_over = 0; m_win = 0; m_draw = 0;
            return;
        end
        m_next = 0; m_draw = 0;
        case (m_ph)
            PH_IDLE: if (go) m_ph = PH_SPAWN;
            PH_SPAWN: begin
                nb = (num_blocks == 0) ? 1 : int'(num_blocks);
                m_w = (nb < pop16(m_base)) ? nb : pop16(m_base);
                if (m_w < 1) m_w = 1;
                m_pos = 0; m_dir = 1; m_cnt = 0;
                m_row = mk(m_w, 0); m_draw = 1; m_ph = PH_MOVE;
            end
            PH_MOVE: begin
                if (place) m_ph = PH_LOCK;
                else if (frame_tick) begin
                    sp = (speed_count == 0) ? 1 : int'(speed_count);
                    if (m_cnt + 1 >= sp) begin
                        m_cnt = 0;
                        if (m_w < COLS) begin
                            np = m_pos + m_dir;
                            if (np < 0 || np > COLS - m_w) begin
                                m_dir = -m_dir;
                                np = m_pos + m_dir;
                            end
                            m_pos = np; m_row = mk(m_w, m_pos); m_draw = 1;
                        end
                    end else m_cnt = m_cnt + 1;
                end
            end
            PH_LOCK: begin
                ovl = int'(m_row & m_base);
                if (ovl == 0) m_ph = PH_OVER;
                else begin m_base = m_row & m_base; m_draw = 1; m_ph = PH_ADV; end
            end
            PH_ADV: begin
                m_next = 1;
                m_ph = (curr_level >= 15) ? PH_WIN : PH_SPAWN;
            end
            default: begin // OVER / WIN
                if (go) begin
                    m_draw = (m_base != 16'hFFFF);
                    m_base = 16'hFFFF; m_over = 0; m_win = 0; m_ph = PH_SPAWN;
                end else if (m_ph == PH_OVER) m_over = 1;
                else m_win = 1;
            end
        endcase
    endtask

    // ---------------- opening sequence table ----------------
    typedef struct packed {
        logic        go, place, tick;
        logic [15:0] row, base;
        logic        nxt, draw;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0007, 16'hFFFF, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h000E, 16'hFFFF, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h001C, 16'hFFFF, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h001C, 16'hFFFF, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0038, 16'hFFFF, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0070, 16'hFFFF, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h00E0, 16'hFFFF, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h00E0, 16'hFFFF, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h00E0, 16'h00E0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h00E0, 16'h00E0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0007, 16'h00E0, 1'b0, 1'b1};

        speed_count = 6'd1; num_blocks = 4'd3; curr_level = 4'd1;
        do_reset();

        // Reset values
        chk("rst_row", 32'(row_mask), 32'h0);
        chk("rst_base", 32'(base_mask), 32'hFFFF);
        chk("rst_flags", {28'd0, next_signal, game_over, win, draw_req}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            go = tbl[i].go; place = tbl[i].place; frame_tick = tbl[i].tick;
            step();
            chk($sformatf("tbl%0d_row", i),  32'(row_mask),    32'(tbl[i].row));
            chk($sformatf("tbl%0d_base", i), 32'(base_mask),   32'(tbl[i].base));
            chk($sformatf("tbl%0d_next", i), 32'(next_signal), 32'(tbl[i].nxt));
            chk($sformatf("tbl%0d_draw", i), 32'(draw_req),    32'(tbl[i].draw));
        end
        go = 1'b0; place = 1'b0; frame_tick = 1'b0;

        // Right-wall bounce
        do_reset(); speed_count = 6'd1; num_blocks = 4'd3;
        start_round();
        ticks(13);
        chk("wall_row", 32'(row_mask), 32'hE000);
        ticks(1);
        chk("bounce_row", 32'(row_mask), 32'h7000);
        ticks(1);
        chk("bounce2_row", 32'(row_mask), 32'h3800);

        // Partial overlap trims the row
        do_reset(); num_blocks = 4'd4;
        start_round();
        ticks(4);
        chk("p3_setup_row", 32'(row_mask), 32'h00F0);
        place_now(); num_blocks = 4'd3;
        step(); step(); step();
        chk("p3_base_f0", 32'(base_mask), 32'h00F0);
        ticks(6);
        chk("p3_row_1c0", 32'(row_mask), 32'h01C0);
        place_now();
        chk("p3_next_p0", 32'(next_signal), 32'h0);
        step();
        chk("p3_base_c0", 32'(base_mask), 32'h00C0);
        chk("p3_next_p1", 32'(next_signal), 32'h0);
        step();
        chk("p3_next_p2", 32'(next_signal), 32'h1);
        step();
        chk("p3_new_w2", 32'(row_mask), 32'h0003);
        chk("p3_next_off", 32'(next_signal), 32'h0);

        // Miss -> game over, then restart
        do_reset(); num_blocks = 4'd4;
        start_round();
        place_now(); step(); step();
        num_blocks = 4'd3;
        step();
        chk("p4_base_f", 32'(base_mask), 32'h000F);
        ticks(4);
        chk("p4_row_70", 32'(row_mask), 32'h0070);
        place_now();
        step();
        chk("p4_over_p1", {30'd0, game_over, next_signal}, 32'h0);
        step();
        chk("p4_over_p2", {30'd0, game_over, next_signal}, 32'h2);
        place_now();
        chk("p4_over_hold", {30'd0, game_over, next_signal}, 32'h2);
        chk("p4_base_hold", 32'(base_mask), 32'h000F);
        go = 1'b1; step(); go = 1'b0;
        chk("p4_restart_base", 32'(base_mask), 32'hFFFF);
        chk("p4_restart_over", 32'(game_over), 32'h0);
        step();
        chk("p4_spawn_row", 32'(row_mask), 32'h0007);

        // Win at max level
        do_reset(); curr_level = 4'd15; num_blocks = 4'd3;
        start_round();
        place_now(); step(); step();
        chk("p5_next", {30'd0, next_signal, win}, 32'h2);
        step();
        chk("p5_win", {30'd0, next_signal, win}, 32'h1);
        place_now(); step();
        chk("p5_win_hold", 32'(win), 32'h1);
        chk("p5_base", 32'(base_mask), 32'h0007);
        chk("p5_row", 32'(row_mask), 32'h0007);

        // Place and step collide; reset mid-MOVE
        do_reset(); curr_level = 4'd1; speed_count = 6'd1; num_blocks = 4'd3;
        start_round();
        ticks(1);
        place = 1'b1; frame_tick = 1'b1; step();
        place = 1'b0; frame_tick = 1'b0;
        chk("p6_no_step", 32'(row_mask), 32'h000E);
        step();
        chk("p6_lock_pre", 32'(base_mask), 32'h000E);
        step(); step();
        ticks(1);
        chk("p6_moving", 32'(row_mask), 32'h000E);
        resetn = 1'b1; step(); resetn = 1'b0;
        chk("p6_rst_row", 32'(row_mask), 32'h0);
        chk("p6_rst_base", 32'(base_mask), 32'hFFFF);
        chk("p6_rst_flags", {28'd0, next_signal, game_over, win, draw_req}, 32'h0);

        // Random stimulus against the reference model
        resetn = 1'b1; model_step(); step();
        resetn = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            resetn      = ($urandom_range(0, 299) == 0);
            go          = ($urandom_range(0, 11) == 0);
            place       = ($urandom_range(0, 5) == 0);
            frame_tick  = ($urandom_range(0, 1) == 0);
            speed_count = 6'($urandom_range(0, 3));
            num_blocks  = 4'($urandom_range(0, 15));
            curr_level  = 4'($urandom_range(1, 15));
            model_step();
            step();
            chk("rnd_row",  32'(row_mask),    32'(m_row));
            chk("rnd_base", 32'(base_mask),   32'(m_base));
            chk("rnd_next", 32'(next_signal), 32'(m_next));
            chk("rnd_over", 32'(game_over),   32'(m_over));
            chk("rnd_win",  32'(win),         32'(m_win));
            chk("rnd_draw", 32'(draw_req),    32'(m_draw));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
